// File: rtl/map_ram_arbiter.sv
// Arbitrates the single-port tile map RAM between video scan-out, movement lookup and pellet-clear writes.
// Optional MAP_ARB_STATS_EN adds saturating vid_miss / write-grant statistics counters.
module map_ram_arbiter #(
  parameter int MAP_DEPTH    = 1152,
  parameter int ADDR_W       = 11,
  parameter int DATA_W       = 4,
  parameter int STARVE_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_miss,
  input  logic              mv_req,
  input  logic [ADDR_W-1:0] mv_addr,
  output logic              mv_gnt,
  output logic              mv_rvalid,
  output logic [DATA_W-1:0] mv_rdata,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef MAP_ARB_STATS_EN
  ,
  output logic [15:0]       stat_vid_miss,
  output logic [15:0]       stat_wr_cnt
`endif
);

  localparam logic [1:0]      OWN_NONE = 2'd0;
  localparam logic [1:0]      OWN_VID  = 2'd1;
  localparam logic [1:0]      OWN_MV   = 2'd2;
  localparam logic [3:0]      LIMIT    = 4'(STARVE_LIMIT);
  localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(MAP_DEPTH);

  logic [3:0]        starve_mv_q, starve_mv_d;
  logic [3:0]        starve_wr_q, starve_wr_d;
  logic              rr_q, rr_d;          // 0 = mv next, 1 = wr next
  logic [1:0]        rd_owner_q, rd_owner_d;
  logic              rd_zero_q, rd_zero_d;
  logic [DATA_W-1:0] vid_hold_q, mv_hold_q;

  logic              gnt_vid;
  logic              force_mv, force_wr;
  logic              in_range;
  logic [DATA_W-1:0] rd_val;

  assign force_mv = mv_req && (starve_mv_q >= LIMIT);
  assign force_wr = wr_req && (starve_wr_q >= LIMIT);

  always_comb begin
    gnt_vid   = 1'b0;
    mv_gnt    = 1'b0;
    wr_gnt    = 1'b0;
    vid_miss  = 1'b0;
    rr_d      = rr_q;
    // Nothing may be granted while reset is held, so outputs drop at once.
    if (!rst) begin
      if (force_mv && force_wr) begin
        mv_gnt = ~rr_q;
        wr_gnt = rr_q;
        rr_d   = ~rr_q;
      end else if (force_mv) begin
        mv_gnt = 1'b1;
      end else if (force_wr) begin
        wr_gnt = 1'b1;
      end else if (vid_req) begin
        gnt_vid = 1'b1;
      end else if (mv_req && wr_req) begin
        mv_gnt = ~rr_q;
        wr_gnt = rr_q;
        rr_d   = ~rr_q;
      end else if (mv_req) begin
        mv_gnt = 1'b1;
      end else if (wr_req) begin
        wr_gnt = 1'b1;
      end
      vid_miss = vid_req && (force_mv || force_wr);
    end
  end

  always_comb begin
    ram_addr = '0;
    if (gnt_vid)     ram_addr = vid_addr;
    else if (mv_gnt) ram_addr = mv_addr;
    else if (wr_gnt) ram_addr = wr_addr;
  end

  assign in_range  = {1'b0, ram_addr} < DEPTH_L;
  assign ram_en    = (gnt_vid || mv_gnt || wr_gnt) && in_range;
  assign ram_we    = wr_gnt && in_range;
  assign ram_wdata = wr_gnt ? wr_data : '0;

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (gnt_vid)     rd_owner_d = OWN_VID;
    else if (mv_gnt) rd_owner_d = OWN_MV;
    rd_zero_d   = ~in_range;
    starve_mv_d = (mv_req && !mv_gnt) ? ((starve_mv_q == 4'hF) ? 4'hF : starve_mv_q + 4'd1) : 4'd0;
    starve_wr_d = (wr_req && !wr_gnt) ? ((starve_wr_q == 4'hF) ? 4'hF : starve_wr_q + 4'd1) : 4'd0;
  end

  // Out-of-range reads return the empty tile instead of whatever the RAM last drove.
  assign rd_val     = rd_zero_q ? '0 : ram_rdata;
  assign vid_rvalid = (rd_owner_q == OWN_VID);
  assign mv_rvalid  = (rd_owner_q == OWN_MV);
  assign vid_rdata  = vid_rvalid ? rd_val : vid_hold_q;
  assign mv_rdata   = mv_rvalid ? rd_val : mv_hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_mv_q <= '0;
      starve_wr_q <= '0;
      rr_q        <= 1'b0;
      rd_owner_q  <= OWN_NONE;
      rd_zero_q   <= 1'b0;
      vid_hold_q  <= '0;
      mv_hold_q   <= '0;
    end else begin
      starve_mv_q <= starve_mv_d;
      starve_wr_q <= starve_wr_d;
      rr_q        <= rr_d;
      rd_owner_q  <= rd_owner_d;
      rd_zero_q   <= rd_zero_d;
      vid_hold_q  <= vid_rdata;
      mv_hold_q   <= mv_rdata;
    end
  end

`ifdef MAP_ARB_STATS_EN
  logic [15:0] stat_vid_miss_q, stat_wr_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_vid_miss_q <= '0;
      stat_wr_cnt_q   <= '0;
    end else begin
      if (vid_miss && (stat_vid_miss_q != 16'hFFFF)) stat_vid_miss_q <= stat_vid_miss_q + 16'd1;
      if (wr_gnt && (stat_wr_cnt_q != 16'hFFFF))     stat_wr_cnt_q   <= stat_wr_cnt_q + 16'd1;
    end
  end

  assign stat_vid_miss = stat_vid_miss_q;
  assign stat_wr_cnt   = stat_wr_cnt_q;
`endif

endmodule

// File: tb/tb_map_ram_arbiter.sv
// Directed bench for map_ram_arbiter with a write-first registered-read RAM model.
// Covers reset, vid read latency, mv/wr round-robin, starvation override, out-of-range and mid-read reset.
module tb_map_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        vid_req, mv_req, wr_req;
  logic [10:0] vid_addr, mv_addr, wr_addr;
  logic [3:0]  wr_data;
  logic        vid_rvalid, vid_miss, mv_gnt, mv_rvalid, wr_gnt;
  logic [3:0]  vid_rdata, mv_rdata;
  logic        ram_en, ram_we;
  logic [10:0] ram_addr;
  logic [3:0]  ram_wdata;
  logic [3:0]  ram_rdata = 4'h0;
  logic [3:0]  mem [0:1151];
`ifdef MAP_ARB_STATS_EN
  logic [15:0] stat_vid_miss, stat_wr_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  map_ram_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .vid_req    (vid_req),
    .vid_addr   (vid_addr),
    .vid_rvalid (vid_rvalid),
    .vid_rdata  (vid_rdata),
    .vid_miss   (vid_miss),
    .mv_req     (mv_req),
    .mv_addr    (mv_addr),
    .mv_gnt     (mv_gnt),
    .mv_rvalid  (mv_rvalid),
    .mv_rdata   (mv_rdata),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_gnt     (wr_gnt),
    .ram_en     (ram_en),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
`ifdef MAP_ARB_STATS_EN
    ,
    .stat_vid_miss (stat_vid_miss),
    .stat_wr_cnt   (stat_wr_cnt)
`endif
  );

  // Write-first single-port RAM with one cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        ram_rdata     <= ram_wdata;
      end else begin
        ram_rdata <= mem[ram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1152; i++) mem[i] = 4'h0;
    mem[33] = 4'h1;
    mem[5]  = 4'h7;
    rst = 1'b1;
    vid_req = 1'b0; mv_req = 1'b0; wr_req = 1'b0;
    vid_addr = '0; mv_addr = '0; wr_addr = '0; wr_data = '0;
    tick();
    tick();

    // Reset state
    chk("rst_ctrl", {vid_rvalid, mv_rvalid, vid_miss, mv_gnt, wr_gnt, ram_en, ram_we}, 0);
    chk("rst_rdata", {vid_rdata, mv_rdata}, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle", {vid_rvalid, mv_rvalid, vid_miss, mv_gnt, wr_gnt, ram_en, ram_we, vid_rdata, mv_rdata}, 0);
    end

    // Video read of address 33
    vid_req = 1'b1; vid_addr = 11'd33;
    #1;
    chk("vid_ram_en", ram_en, 1);
    chk("vid_ram_addr", ram_addr, 33);
    tick();
    vid_req = 1'b0;
    #1;
    chk("vid_rvalid", vid_rvalid, 1);
    chk("vid_rdata", vid_rdata, 1);
    tick();
    chk("vid_rvalid_pulse", vid_rvalid, 0);
    chk("vid_rdata_hold", vid_rdata, 1);

    // mv and wr held together: round robin mv, wr, mv, wr
    mv_req = 1'b1; mv_addr = 11'd5;
    wr_req = 1'b1; wr_addr = 11'd40; wr_data = 4'h3;
    #1;
    chk("rr0_gnt", {mv_gnt, wr_gnt}, 2'b10);
    tick();
    chk("rr1_gnt", {mv_gnt, wr_gnt, ram_we, ram_en}, 4'b0111);
    chk("rr1_mv_rvalid", {mv_rvalid, mv_rdata}, {1'b1, 4'h7});
    tick();
    chk("rr2_gnt", {mv_gnt, wr_gnt}, 2'b10);
    tick();
    chk("rr3_gnt", {mv_gnt, wr_gnt}, 2'b01);
    tick();
    mv_req = 1'b0; wr_req = 1'b0;

    // Read back the written tile
    mv_req = 1'b1; mv_addr = 11'd40;
    #1;
    chk("rb_gnt", mv_gnt, 1);
    tick();
    mv_req = 1'b0;
    #1;
    chk("rb_data", {mv_rvalid, mv_rdata}, {1'b1, 4'h3});
    tick();

    // Video every cycle starves mv for 15 cycles, then forced grant
    vid_req = 1'b1; vid_addr = 11'd33;
    mv_req = 1'b1; mv_addr = 11'd5;
    for (int i = 1; i <= 15; i++) begin
      #1;
      chk("vid_pri", {mv_gnt, vid_miss, ram_addr}, {1'b0, 1'b0, 11'd33});
      tick();
    end
    #1;
    chk("starve_mv_gnt", mv_gnt, 1);
    chk("starve_vid_miss", vid_miss, 1);
    chk("starve_addr", ram_addr, 5);
    tick();
    mv_req = 1'b0; vid_req = 1'b0;
    #1;
    chk("starve_mv_rvalid", {mv_rvalid, mv_rdata}, {1'b1, 4'h7});
    chk("starve_no_vid_rvalid", {vid_rvalid, vid_miss}, 0);
    tick();

    // Out-of-range write, then out-of-range read
    wr_req = 1'b1; wr_addr = 11'd1152; wr_data = 4'h0;
    #1;
    chk("oor_wr", {wr_gnt, ram_en, ram_we}, 3'b100);
    tick();
    wr_req = 1'b0;
    mv_req = 1'b1; mv_addr = 11'd1200;
    #1;
    chk("oor_rd_gnt", {mv_gnt, ram_en}, 2'b10);
    tick();
    mv_req = 1'b0;
    #1;
    chk("oor_rd_data", {mv_rvalid, mv_rdata}, {1'b1, 4'h0});
    tick();

    // Reset one cycle after a mv grant; rr_ptr must return to mv
    mv_req = 1'b1; mv_addr = 11'd5;
    wr_req = 1'b1; wr_addr = 11'd41; wr_data = 4'h2;
    #1;
    chk("pre_rst_gnt", {mv_gnt, wr_gnt}, 2'b10);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async", {mv_rvalid, mv_gnt, wr_gnt, ram_en, vid_miss}, 0);
    chk("rst_async_rdata", mv_rdata, 0);
    mv_req = 1'b0; wr_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_no_rvalid", {mv_rvalid, vid_rvalid}, 0);
    tick();
    chk("post_rst_no_rvalid2", {mv_rvalid, vid_rvalid}, 0);
    mv_req = 1'b1; wr_req = 1'b1;
    #1;
    chk("post_rst_rr", {mv_gnt, wr_gnt}, 2'b10);
    tick();
    mv_req = 1'b0; wr_req = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
